// File: rtl/frame_mem_ctrl.sv
// Raster-order frame fetch / write-back controller in front of BRAM port A.
// Define FRAME_MEM_CTRL_DBG_CNT_EN to expose the row/col counters on cnt_img_*_o.
module frame_mem_ctrl #(
  parameter int DATA_W  = 8,
  parameter int MAX_ROW = 540,
  parameter int MAX_COL = 540,
  parameter int ADDR_W  = 19,
  parameter int RD_LAT  = 1,
  parameter int WR_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] d2mem_o,
  input  logic [DATA_W-1:0] mem2d_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_en_o,
  input  logic              fetch_run_i,
  input  logic              mode_i,
  output logic              fetch_done_o,
  input  logic [DATA_W-1:0] pixel_i,
  input  logic              pixel_en_i,
  output logic [9:0]        cnt_img_row_o,
  output logic [9:0]        cnt_img_col_o
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_e;

  localparam logic [9:0]        LAST_ROW   = 10'(MAX_ROW - 1);
  localparam logic [9:0]        LAST_COL   = 10'(MAX_COL - 1);
  localparam logic [ADDR_W-1:0] WR_BASE_A  = ADDR_W'(WR_BASE);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  state_e              state_q, state_d;
  logic [9:0]          row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          drain_q, drain_d;
  logic                arm_q, arm_d;
  logic [RD_LAT:1]     vld_pipe_q, vld_pipe_d;
  logic                rd_issue, wr_issue, last_px, active;

  always_comb begin
    active   = (state_q == READ) || (state_q == DRAIN) || (state_q == WRITE);
    rd_issue = (state_q == READ) && fetch_run_i;
    wr_issue = (state_q == WRITE) && fetch_run_i && pixel_en_i;
    last_px  = (row_q == LAST_ROW) && (col_q == LAST_COL);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    // A finished run re-arms only once fetch_run_i has been seen low.
    arm_d   = arm_q | ~fetch_run_i;
    case (state_q)
      IDLE: begin
        row_d   = '0;
        col_d   = '0;
        drain_d = '0;
        if (fetch_run_i && arm_q) begin
          state_d = mode_i ? WRITE : READ;
          addr_d  = mode_i ? WR_BASE_A : '0;
        end
      end
      READ, WRITE: begin
        if (rd_issue || wr_issue) begin
          if (last_px) begin
            state_d = (state_q == READ) ? DRAIN : DONE;
          end else begin
            addr_d = addr_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 10'd1;
            end else begin
              col_d = col_q + 10'd1;
            end
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + 2'd1;
      end
      DONE: begin
        state_d = IDLE;
        arm_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (active && !fetch_run_i) state_d = IDLE;
  end

  // Read-valid shift register; an abort flushes everything in flight.
  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[1] = rd_issue;
    for (int i = 2; i <= RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    if (!fetch_run_i) vld_pipe_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      drain_q    <= '0;
      arm_q      <= 1'b1;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      arm_q      <= arm_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Outputs decode registered state, so reset clears them without waiting for an edge.
  always_comb begin
    ena_o        = rd_issue || wr_issue;
    wea_o        = wr_issue;
    addr_o       = (rd_issue || wr_issue) ? addr_q : '0;
    d2mem_o      = wr_issue ? pixel_i : '0;
    data_en_o    = vld_pipe_q[RD_LAT] && fetch_run_i &&
                   ((state_q == READ) || (state_q == DRAIN));
    // mem2d_i is the BRAM output register, already aligned to the strobe.
    data_o       = data_en_o ? mem2d_i : '0;
    fetch_done_o = (state_q == DONE);
  end

`ifdef FRAME_MEM_CTRL_DBG_CNT_EN
  assign cnt_img_row_o = row_q;
  assign cnt_img_col_o = col_q;
`else
  assign cnt_img_row_o = '0;
  assign cnt_img_col_o = '0;
`endif

endmodule

// File: tb/tb_frame_mem_ctrl.sv
// Bench for frame_mem_ctrl: two instances (RD_LAT=1 and 2) on a 4x3 frame, WR_BASE=100.
module tb_frame_mem_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_run_i, mode_i, pixel_en_i;
  logic [7:0] pixel_i;
  logic       ena [2], wea [2], fd [2], den [2];
  logic [18:0] addr [2];
  logic [7:0] d2m [2], m2d [2], dat [2];
  logic [9:0] crow [2], ccol [2];

  int n_chk = 0, n_fail = 0, cyc = 0, cnt_nz = 0;
  int rd_n [2], ad_n [2], wr_n [2], dn_n [2];
  int rd_cyc [2][1024];
  logic [7:0] rd_dat [2][1024];
  int ad_val [2][1024];
  int wr_adr [2][1024];
  logic [7:0] wr_dat [2][1024];
  int dn_cyc [2][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_mem_ctrl #(.DATA_W(8), .MAX_ROW(4), .MAX_COL(3), .ADDR_W(19), .RD_LAT(1), .WR_BASE(100)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .ena_o(ena[0]), .wea_o(wea[0]), .addr_o(addr[0]), .d2mem_o(d2m[0]),
    .mem2d_i(m2d[0]), .data_o(dat[0]), .data_en_o(den[0]), .fetch_run_i(fetch_run_i), .mode_i(mode_i),
    .fetch_done_o(fd[0]), .pixel_i(pixel_i), .pixel_en_i(pixel_en_i),
    .cnt_img_row_o(crow[0]), .cnt_img_col_o(ccol[0]));

  frame_mem_ctrl #(.DATA_W(8), .MAX_ROW(4), .MAX_COL(3), .ADDR_W(19), .RD_LAT(2), .WR_BASE(100)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .ena_o(ena[1]), .wea_o(wea[1]), .addr_o(addr[1]), .d2mem_o(d2m[1]),
    .mem2d_i(m2d[1]), .data_o(dat[1]), .data_en_o(den[1]), .fetch_run_i(fetch_run_i), .mode_i(mode_i),
    .fetch_done_o(fd[1]), .pixel_i(pixel_i), .pixel_en_i(pixel_en_i),
    .cnt_img_row_o(crow[1]), .cnt_img_col_o(ccol[1]));

  // BRAM preloaded with mem[a] = a; read latency 1 or 2 registered stages.
  logic [7:0] mem [256];
  logic [7:0] bp0;
  logic [7:0] bp1 [2];
  initial for (int a = 0; a < 256; a++) mem[a] = 8'(a);
  always @(posedge clk) begin
    bp0    <= mem[addr[0][7:0]];
    bp1[0] <= mem[addr[1][7:0]];
    bp1[1] <= bp1[0];
  end
  assign m2d[0] = bp0;
  assign m2d[1] = bp1[1];

  initial for (int d = 0; d < 2; d++) begin rd_n[d] = 0; ad_n[d] = 0; wr_n[d] = 0; dn_n[d] = 0; end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (den[d] && rd_n[d] < 1024) begin
        rd_cyc[d][rd_n[d]] = cyc; rd_dat[d][rd_n[d]] = dat[d]; rd_n[d]++;
      end
      if (ena[d] && !wea[d] && ad_n[d] < 1024) begin
        ad_val[d][ad_n[d]] = int'(addr[d]); ad_n[d]++;
      end
      if (ena[d] && wea[d] && wr_n[d] < 1024) begin
        wr_adr[d][wr_n[d]] = int'(addr[d]); wr_dat[d][wr_n[d]] = d2m[d]; wr_n[d]++;
      end
      if (fd[d] && dn_n[d] < 1024) begin
        dn_cyc[d][dn_n[d]] = cyc; dn_n[d]++;
      end
      if (crow[d] != 10'd0 || ccol[d] != 10'd0) cnt_nz++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic all_out_zero(input string nm);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s_lat%0d", nm, d + 1),
          int'({ena[d], wea[d], fd[d], den[d]}) + int'(addr[d]) + int'(d2m[d]) + int'(dat[d]), 0);
  endtask

  typedef struct {
    logic mode;      // 0 read, 1 write-back
    int   gap;       // cycles per pixel in write mode, 0 = random 1..3
    logic rnd_pix;
    int   done_lat1; // fetch_done cycle minus start cycle, -1 = derive from pixel timing
    int   done_lat2;
  } vec_t;

  // One run from the current cycle (caller is at posedge+1).
  task automatic run_vec(input vec_t v, input string tag);
    int s, last_pix, g, errs, k, exp_done;
    int b_rd [2], b_ad [2], b_wr [2], b_dn [2];
    logic [7:0] pix [12];
    for (int d = 0; d < 2; d++) begin b_rd[d] = rd_n[d]; b_ad[d] = ad_n[d]; b_wr[d] = wr_n[d]; b_dn[d] = dn_n[d]; end
    for (int i = 0; i < 12; i++) pix[i] = v.rnd_pix ? 8'($urandom) : 8'(8'hA0 + i);
    s = cyc; last_pix = s;
    fetch_run_i = 1'b1; mode_i = v.mode; pixel_en_i = 1'b1; pixel_i = 8'hEE;
    if (v.mode) begin
      for (int i = 0; i < 12; i++) begin
        g = (v.gap == 0) ? int'($urandom_range(3, 1)) : v.gap;
        for (int w = 0; w < g; w++) begin
          @(posedge clk); #1;
          pixel_en_i = (w == 0);
          pixel_i    = (w == 0) ? pix[i] : 8'($urandom);
          mode_i     = 1'($urandom);
          if (w == 0) last_pix = cyc;
        end
      end
    end
    while (cyc < s + 45) begin
      @(posedge clk); #1;
      pixel_en_i = 1'($urandom); pixel_i = 8'($urandom); mode_i = 1'($urandom);
    end
    fetch_run_i = 1'b0; pixel_en_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    for (int d = 0; d < 2; d++) begin
      exp_done = (d == 0) ? v.done_lat1 : v.done_lat2;
      if (exp_done < 0) exp_done = last_pix - s + 1;
      chk($sformatf("%s_done_cnt_lat%0d", tag, d + 1), dn_n[d] - b_dn[d], 1);
      chk($sformatf("%s_done_lat_lat%0d", tag, d + 1),
          (dn_n[d] > b_dn[d]) ? dn_cyc[d][b_dn[d]] - s : -1, exp_done);
      errs = 0;
      if (!v.mode) begin
        chk($sformatf("%s_rd_cnt_lat%0d", tag, d + 1), rd_n[d] - b_rd[d], 12);
        chk($sformatf("%s_addr_cnt_lat%0d", tag, d + 1), ad_n[d] - b_ad[d], 12);
        chk($sformatf("%s_first_strobe_lat%0d", tag, d + 1),
            (rd_n[d] > b_rd[d]) ? rd_cyc[d][b_rd[d]] - s : -1, 1 + (d + 1));
        for (int i = 0; i < 12; i++) begin
          k = b_rd[d] + i;
          if (rd_dat[d][k] !== 8'(i) || rd_cyc[d][k] != s + 1 + i + (d + 1) || ad_val[d][b_ad[d] + i] != i) errs++;
        end
        chk($sformatf("%s_rd_seq_errs_lat%0d", tag, d + 1), errs, 0);
        chk($sformatf("%s_wr_cnt_lat%0d", tag, d + 1), wr_n[d] - b_wr[d], 0);
      end else begin
        chk($sformatf("%s_wr_cnt_lat%0d", tag, d + 1), wr_n[d] - b_wr[d], 12);
        for (int i = 0; i < 12; i++) begin
          k = b_wr[d] + i;
          if (wr_adr[d][k] != 100 + i || wr_dat[d][k] !== pix[i]) errs++;
        end
        chk($sformatf("%s_wr_seq_errs_lat%0d", tag, d + 1), errs, 0);
        chk($sformatf("%s_rd_cnt_lat%0d", tag, d + 1), rd_n[d] - b_rd[d], 0);
      end
    end
  endtask

  vec_t tbl [6];

  initial begin
    int s, exp_rd;
    int b_rd [2], b_ad [2], b_dn [2];
    logic strobe_late;
    tbl[0] = '{mode: 1'b0, gap: 1, rnd_pix: 1'b0, done_lat1: 14, done_lat2: 15};
    tbl[1] = '{mode: 1'b1, gap: 2, rnd_pix: 1'b0, done_lat1: 24, done_lat2: 24};
    tbl[2] = '{mode: 1'b1, gap: 1, rnd_pix: 1'b1, done_lat1: 13, done_lat2: 13};
    tbl[3] = '{mode: 1'b1, gap: 3, rnd_pix: 1'b1, done_lat1: 35, done_lat2: 35};
    tbl[4] = '{mode: 1'b1, gap: 0, rnd_pix: 1'b1, done_lat1: -1, done_lat2: -1};
    tbl[5] = '{mode: 1'b0, gap: 1, rnd_pix: 1'b0, done_lat1: 14, done_lat2: 15};

    // Reset with every input active: outputs must stay quiet.
    rst_n = 1'b0; fetch_run_i = 1'b1; mode_i = 1'b1; pixel_en_i = 1'b1; pixel_i = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    all_out_zero("reset_state");
    fetch_run_i = 1'b0; pixel_en_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    // Abort: drop fetch_run_i after five read addresses.
    for (int d = 0; d < 2; d++) begin b_rd[d] = rd_n[d]; b_ad[d] = ad_n[d]; b_dn[d] = dn_n[d]; end
    s = cyc; fetch_run_i = 1'b1; mode_i = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    fetch_run_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    for (int d = 0; d < 2; d++) begin
      exp_rd = 0;
      for (int i = 0; i < 5; i++) if (s + 1 + i + (d + 1) < s + 6) exp_rd++;
      strobe_late = 1'b0;
      for (int k = b_rd[d]; k < rd_n[d]; k++) if (rd_cyc[d][k] >= s + 6) strobe_late = 1'b1;
      chk($sformatf("abort_addr_cnt_lat%0d", d + 1), ad_n[d] - b_ad[d], 5);
      chk($sformatf("abort_strobe_cnt_lat%0d", d + 1), rd_n[d] - b_rd[d], exp_rd);
      chk($sformatf("abort_late_strobe_lat%0d", d + 1), int'(strobe_late), 0);
      chk($sformatf("abort_done_cnt_lat%0d", d + 1), dn_n[d] - b_dn[d], 0);
    end
    run_vec(tbl[0], "rerun");

    // Asynchronous reset in the middle of a write run.
    fetch_run_i = 1'b1; mode_i = 1'b1; pixel_en_i = 1'b1; pixel_i = 8'h3C;
    repeat (4) begin @(posedge clk); #1; end
    for (int d = 0; d < 2; d++) chk($sformatf("pre_rst_ena_lat%0d", d + 1), int'(ena[d] & wea[d]), 1);
    #2 rst_n = 1'b0;
    #1 all_out_zero("rst_async");
    @(posedge clk); #1;
    all_out_zero("rst_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(tbl[2], "post_rst");

`ifdef FRAME_MEM_CTRL_DBG_CNT_EN
    chk("cnt_tracks", int'(cnt_nz > 0), 1);
`else
    chk("cnt_zero", cnt_nz, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
